cdc_mcp_arbiter: RTL and testbench

//   Source-side scheduler for a shared multi-cycle-path toggle CDC channel. Arbitrates NUM_REQ

---
 rtl/cdc_mcp_arbiter_if.sv | 25 ++
 rtl/cdc_mcp_arbiter.sv | 128 ++++++++++++
 tb/tb_cdc_mcp_arbiter.sv | 361 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cdc_mcp_arbiter_if.sv
// Requester/channel bundle for the multi-cycle-path CDC source scheduler.
// Arbiter uses the slave view; the requester side uses the master view.
interface cdc_mcp_arbiter_if #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 8
);
   localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [NUM_REQ-1:0]            REQ_I;
   logic [NUM_REQ*DATA_WIDTH-1:0] DATA_I;
   logic [NUM_REQ-1:0]            GNT_O;
   logic                          STA_O;
   logic [IDW+DATA_WIDTH-1:0]     DA_O;
   logic                          BUSY_O;

   modport master (
      output REQ_I, DATA_I,
      input  GNT_O, STA_O, DA_O, BUSY_O
   );

   modport slave (
      input  REQ_I, DATA_I,
      output GNT_O, STA_O, DA_O, BUSY_O
   );
endinterface

// File: rtl/cdc_mcp_arbiter.sv
// Round-robin source scheduler for a shared toggle CDC channel.
// Spaces store pulses by GAP hold cycles so the far side always settles.
module cdc_mcp_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 8,
   parameter int GAP        = 8
) (
   input logic               CLK_I,
   input logic               RST_NI,
   cdc_mcp_arbiter_if.slave  bus
);
   localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int GW  = (GAP > 1) ? $clog2(GAP) : 1;
   localparam logic [GW-1:0]  GAP_LD = GW'(GAP - 1);
   localparam logic [IDW:0]   NREQ   = (IDW+1)'(NUM_REQ);
   localparam logic [IDW-1:0] LAST   = IDW'(NUM_REQ - 1);

   generate
      if (GAP < 1 || NUM_REQ < 1) begin : g_bad_param
         $error("cdc_mcp_arbiter: GAP and NUM_REQ must be >= 1");
      end
   endgenerate

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      STORE = 2'd1,
      HOLD  = 2'd2
   } state_e;

   state_e                    state_q, state_d;
   logic [IDW-1:0]            ptr_q, ptr_d;
   logic [GW-1:0]             gap_q, gap_d;
   logic                      sta_q, sta_d;
   logic [NUM_REQ-1:0]        gnt_q, gnt_d;
   logic [IDW+DATA_WIDTH-1:0] da_q, da_d;
   logic                      busy_q, busy_d;

   logic [DATA_WIDTH-1:0] dat [NUM_REQ];
   logic                  found;
   logic [IDW-1:0]        win;
   logic [IDW:0]          sum;
   logic [IDW-1:0]        idx;

   always_comb begin
      for (int i = 0; i < NUM_REQ; i++) begin
         dat[i] = bus.DATA_I[i*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   // Scan from ptr upward with wrap; first set request wins.
   always_comb begin
      found = 1'b0;
      win   = '0;
      sum   = '0;
      idx   = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         sum = {1'b0, ptr_q} + (IDW+1)'(k);
         if (sum >= NREQ) begin
            sum = sum - NREQ;
         end
         idx = sum[IDW-1:0];
         if (!found && bus.REQ_I[idx]) begin
            found = 1'b1;
            win   = idx;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      gap_d   = gap_q;
      sta_d   = 1'b0;
      gnt_d   = '0;
      da_d    = da_q;
      unique case (state_q)
         IDLE: begin
            if (found) begin
               state_d = STORE;
               sta_d   = 1'b1;
               gnt_d   = NUM_REQ'(1) << win;
               da_d    = {win, dat[win]};
               ptr_d   = (win == LAST) ? '0 : win + IDW'(1);
            end
         end
         STORE: begin
            state_d = HOLD;
            gap_d   = GAP_LD;
         end
         HOLD: begin
            if (gap_q == '0) begin
               state_d = IDLE;
            end else begin
               gap_d = gap_q - GW'(1);
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge CLK_I or negedge RST_NI) begin
      if (!RST_NI) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         gap_q   <= '0;
         sta_q   <= 1'b0;
         gnt_q   <= '0;
         da_q    <= '0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         gap_q   <= gap_d;
         sta_q   <= sta_d;
         gnt_q   <= gnt_d;
         da_q    <= da_d;
         busy_q  <= busy_d;
      end
   end

   assign bus.STA_O  = sta_q;
   assign bus.GNT_O  = gnt_q;
   assign bus.DA_O   = da_q;
   assign bus.BUSY_O = busy_q;
endmodule

// File: tb/tb_cdc_mcp_arbiter.sv
// Directed bench for cdc_mcp_arbiter, including a toggle-channel model
// on a 3x slower clock fed by a second instance with GAP=11.
module tb_cdc_mcp_arbiter;
   localparam int NR = 4;
   localparam int DW = 8;

   logic clk   = 1'b0;
   logic clkb  = 1'b0;
   logic rst_n = 1'b0;
   int   total = 0;
   int   bad   = 0;

   cdc_mcp_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW)) bus  ();
   cdc_mcp_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW)) bus2 ();

   cdc_mcp_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .GAP(8)) dut (
      .CLK_I  (clk),
      .RST_NI (rst_n),
      .bus    (bus)
   );

   cdc_mcp_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .GAP(11)) dut2 (
      .CLK_I  (clk),
      .RST_NI (rst_n),
      .bus    (bus2)
   );

   always #5 clk = ~clk;
   initial begin
      #7;
      forever #15 clkb = ~clkb;
   end

   // Toggle channel: source register + toggle on clk, 3-flop sync on clkb.
   logic [9:0] src_q;
   logic       tgl_q;
   logic       s1, s2, s3;
   logic [9:0] exp_q [$];
   logic [9:0] e2e_exp;
   int         rx_n = 0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tgl_q <= 1'b0;
         src_q <= '0;
      end else if (bus2.STA_O) begin
         src_q <= bus2.DA_O;
         tgl_q <= ~tgl_q;
         exp_q.push_back(bus2.DA_O);
      end
   end

   always @(posedge clkb or negedge rst_n) begin
      if (!rst_n) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
         s3 <= 1'b0;
      end else begin
         s1 <= tgl_q;
         s2 <= s1;
         s3 <= s2;
         if (s2 ^ s3) begin
            rx_n++;
            total++;
            if (exp_q.size() == 0) begin
               bad++;
               $display("FAIL e2e_dup got=%h want=none", src_q);
            end else begin
               e2e_exp = exp_q.pop_front();
               if (src_q !== e2e_exp) begin
                  bad++;
                  $display("FAIL e2e_data got=%h want=%h", src_q, e2e_exp);
               end
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (bus.BUSY_O && n < 50) begin
         tick();
         n++;
      end
      total++;
      if (bus.BUSY_O !== 1'b0) begin
         bad++;
         $display("FAIL idle_timeout got=%b want=0", bus.BUSY_O);
      end
   endtask

   task automatic test_reset();
      rst_n       = 1'b0;
      bus.REQ_I   = 4'hF;
      bus.DATA_I  = 32'hFFFF_FFFF;
      bus2.REQ_I  = '0;
      bus2.DATA_I = '0;
      repeat (3) tick();
      total += 4;
      if (bus.STA_O !== 1'b0) begin
         bad++; $display("FAIL rst_sta got=%b want=0", bus.STA_O);
      end
      if (bus.GNT_O !== 4'h0) begin
         bad++; $display("FAIL rst_gnt got=%h want=0", bus.GNT_O);
      end
      if (bus.DA_O !== 10'h000) begin
         bad++; $display("FAIL rst_da got=%h want=000", bus.DA_O);
      end
      if (bus.BUSY_O !== 1'b0) begin
         bad++; $display("FAIL rst_busy got=%b want=0", bus.BUSY_O);
      end
      @(negedge clk);
      bus.REQ_I = 4'h0;
      rst_n     = 1'b1;
   endtask

   task automatic test_single();
      int busy_n;
      int sta_n;
      tick();
      bus.DATA_I = {8'h00, 8'hA5, 8'h00, 8'h00};
      bus.REQ_I  = 4'b0100;
      tick();
      total += 3;
      if (bus.GNT_O !== 4'b0100) begin
         bad++; $display("FAIL single_gnt got=%b want=0100", bus.GNT_O);
      end
      if (bus.STA_O !== 1'b1) begin
         bad++; $display("FAIL single_sta got=%b want=1", bus.STA_O);
      end
      if (bus.DA_O !== 10'h2A5) begin
         bad++; $display("FAIL single_da got=%h want=2a5", bus.DA_O);
      end
      bus.REQ_I = 4'b0000;
      busy_n = int'(bus.BUSY_O);
      sta_n  = 0;
      repeat (11) begin
         tick();
         busy_n += int'(bus.BUSY_O);
         sta_n  += int'(bus.STA_O);
      end
      total += 2;
      if (busy_n != 9) begin
         bad++; $display("FAIL single_busy_len got=%0d want=9", busy_n);
      end
      if (sta_n != 0) begin
         bad++; $display("FAIL single_extra_sta got=%0d want=0", sta_n);
      end
   endtask

   task automatic test_fairness();
      int cyc;
      int ng;
      int last;
      int ex;
      logic [9:0] e;
      rst_n = 1'b0;
      tick();
      @(negedge clk);
      bus.DATA_I = {8'h44, 8'h33, 8'h22, 8'h11};
      bus.REQ_I  = 4'hF;
      rst_n      = 1'b1;
      cyc  = 0;
      ng   = 0;
      last = 0;
      while (ng < 8 && cyc < 200) begin
         tick();
         cyc++;
         if (bus.STA_O) begin
            ex = ng % 4;
            e  = {2'(ex), 8'(8'h11 * (ex + 1))};
            total += 2;
            if (bus.GNT_O !== 4'(1 << ex)) begin
               bad++;
               $display("FAIL fair_gnt n=%0d got=%b want=%0d", ng, bus.GNT_O, ex);
            end
            if (bus.DA_O !== e) begin
               bad++;
               $display("FAIL fair_da n=%0d got=%h want=%h", ng, bus.DA_O, e);
            end
            if (ng > 0) begin
               total++;
               if (cyc - last != 10) begin
                  bad++;
                  $display("FAIL fair_period got=%0d want=10", cyc - last);
               end
            end
            last = cyc;
            ng++;
         end
      end
      total++;
      if (ng != 8) begin
         bad++; $display("FAIL fair_timeout got=%0d want=8", ng);
      end
      bus.REQ_I = 4'h0;
      wait_idle();
   endtask

   task automatic test_wrap();
      int cyc;
      int ng;
      logic [3:0] want [3];
      want[0] = 4'b0001;
      want[1] = 4'b0010;
      want[2] = 4'b0001;
      bus.REQ_I = 4'b0100;
      tick();
      total++;
      if (bus.GNT_O !== 4'b0100) begin
         bad++; $display("FAIL wrap_setup got=%b want=0100", bus.GNT_O);
      end
      bus.REQ_I = 4'b0011;
      cyc = 0;
      ng  = 0;
      while (ng < 3 && cyc < 100) begin
         tick();
         cyc++;
         if (bus.STA_O) begin
            total++;
            if (bus.GNT_O !== want[ng]) begin
               bad++;
               $display("FAIL wrap_gnt n=%0d got=%b want=%b", ng, bus.GNT_O, want[ng]);
            end
            ng++;
         end
      end
      total++;
      if (ng != 3) begin
         bad++; $display("FAIL wrap_timeout got=%0d want=3", ng);
      end
      bus.REQ_I = 4'h0;
      wait_idle();
   endtask

   task automatic test_hold_ignore();
      int sta_n;
      bus.REQ_I = 4'b0001;
      tick();
      total++;
      if (bus.GNT_O !== 4'b0001) begin
         bad++; $display("FAIL hold_first got=%b want=0001", bus.GNT_O);
      end
      bus.REQ_I = 4'b0000;
      sta_n = 0;
      repeat (2) tick();
      bus.REQ_I = 4'b1000;
      repeat (4) begin
         tick();
         sta_n += int'(bus.STA_O);
      end
      bus.REQ_I = 4'b0000;
      repeat (12) begin
         tick();
         sta_n += int'(bus.STA_O);
      end
      total++;
      if (sta_n != 0) begin
         bad++; $display("FAIL hold_ignore got=%0d want=0", sta_n);
      end
   endtask

   task automatic test_reset_midop();
      bus.DATA_I = {8'h00, 8'h77, 8'h3C, 8'h00};
      bus.REQ_I  = 4'b0100;
      tick();
      total++;
      if (bus.STA_O !== 1'b1) begin
         bad++; $display("FAIL mid_store got=%b want=1", bus.STA_O);
      end
      #2;
      rst_n = 1'b0;
      #1;
      total += 3;
      if (bus.STA_O !== 1'b0) begin
         bad++; $display("FAIL mid_async_sta got=%b want=0", bus.STA_O);
      end
      if (bus.GNT_O !== 4'h0) begin
         bad++; $display("FAIL mid_async_gnt got=%b want=0", bus.GNT_O);
      end
      if (bus.BUSY_O !== 1'b0) begin
         bad++; $display("FAIL mid_async_busy got=%b want=0", bus.BUSY_O);
      end
      bus.REQ_I = 4'b0010;
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      total += 3;
      if (bus.GNT_O !== 4'b0010) begin
         bad++; $display("FAIL mid_gnt got=%b want=0010", bus.GNT_O);
      end
      if (bus.DA_O !== 10'h13C) begin
         bad++; $display("FAIL mid_da got=%h want=13c", bus.DA_O);
      end
      if (bus.STA_O !== 1'b1) begin
         bad++; $display("FAIL mid_sta got=%b want=1", bus.STA_O);
      end
      bus.REQ_I = 4'h0;
      wait_idle();
   endtask

   task automatic test_e2e();
      int ids [6];
      int n;
      logic [7:0] dv;
      ids = '{0, 3, 1, 2, 2, 1};
      for (int k = 0; k < 6; k++) begin
         dv = 8'(8'h60 + 7 * k);
         bus2.DATA_I = {4{dv}};
         bus2.REQ_I  = 4'(1 << ids[k]);
         n = 0;
         tick();
         while (bus2.GNT_O == 4'h0 && n < 40) begin
            tick();
            n++;
         end
         total++;
         if (bus2.GNT_O !== 4'(1 << ids[k])) begin
            bad++;
            $display("FAIL e2e_gnt k=%0d got=%b want=%0d", k, bus2.GNT_O, ids[k]);
         end
         bus2.REQ_I = 4'h0;
      end
      n = 0;
      while (rx_n < 6 && n < 300) begin
         tick();
         n++;
      end
      total += 2;
      if (rx_n != 6) begin
         bad++; $display("FAIL e2e_count got=%0d want=6", rx_n);
      end
      if (exp_q.size() != 0) begin
         bad++; $display("FAIL e2e_lost got=%0d want=0", exp_q.size());
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single();
      test_fairness();
      test_wrap();
      test_hold_ignore();
      test_reset_midop();
      test_e2e();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
